jtag_tap_mr: RTL and testbench

Parametrised multi-register JTAG TAP controller. It is the successor to the first-generation TAP, adding:
- IEEE 1149.1-compliant IR capture, an explicit 1-bit BYPASS and a forced IDCODE LSB.
- Per-register DR lengths up to MAX_DR_WIDTH.
- Pause-safe shifting, a TDO output-enable, and capture/update strobes for a downstream debug-module register file.

It sits between the chip-level JTAG pins and the debug transport module.

---
 rtl/jtag_tap_mr.sv | 193 +++++++++++++++++++
 tb/tb_jtag_tap_mr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_mr.sv
// jtag_tap_mr: multi-register JTAG TAP controller.
// Standard 16-state TAP FSM with an IR that is reloaded with the IDCODE
// instruction in TEST_LOGIC_RESET. It has an IDCODE DR and a 1-bit BYPASS DR.
// It also has NUM_CUST_REGS custom DRs with per-register lengths, served through
// capture/update strobes to a downstream register file.
// Ports:
//   tck_i, trst_n_i          JTAG clock, async active-low reset
//   tms_i, tdi_i             sampled on posedge tck_i
//   tdo_o, tdo_oe_o          launched on negedge tck_i, enabled only while shifting
//   tap_state_o, ir_o        current TAP state and active instruction
//   cust_rg_val_o/addr_o     active IR selects custom register <addr>
//   cust_rg_dat_i            capture data (low WIDTH[addr] bits used)
//   cust_rg_dat_o            update data, zero-extended
//   cust_rg_capture_o        high while in CAP_DR for a custom register
//   cust_rg_update_o         high while in UPD_DR for a custom register
//
// state  | meaning
// TLR    | test-logic reset, IR forced to IDCODE
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture selected DR
// SH_DR  | shift selected DR
// EX1_DR | exit1 DR
// PAU_DR | pause DR, shift register held
// EX2_DR | exit2 DR
// UPD_DR | update DR
// SEL_IR | select IR scan
// CAP_IR | capture 0..01 into IR shift register
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR
// EX2_IR | exit2 IR
// UPD_IR | latch new instruction
module jtag_tap_mr #(
  parameter logic [31:0]          IDCODE        = 32'h0000_0001,
  parameter int unsigned          IR_WIDTH      = 5,
  parameter logic [IR_WIDTH-1:0]  IR_IDCODE     = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]  IR_BYPASS     = '1,
  parameter int unsigned          MAX_DR_WIDTH  = 64,
  parameter int unsigned          NUM_CUST_REGS = 2,
  parameter logic [((NUM_CUST_REGS > 0) ? NUM_CUST_REGS : 1)*IR_WIDTH-1:0] CUST_REG_ADDRS  = {5'h11, 5'h10},
  parameter logic [((NUM_CUST_REGS > 0) ? NUM_CUST_REGS : 1)*8-1:0]        CUST_REG_WIDTHS = {8'd41, 8'd32},
  localparam int unsigned CUST_REGIF_ADDRW = (NUM_CUST_REGS > 1) ? $clog2(NUM_CUST_REGS) : 1
) (
  input  logic                        tck_i,
  input  logic                        trst_n_i,
  input  logic                        tms_i,
  input  logic                        tdi_i,
  output logic                        tdo_o,
  output logic                        tdo_oe_o,
  output logic [3:0]                  tap_state_o,
  output logic [IR_WIDTH-1:0]         ir_o,
  output logic                        cust_rg_val_o,
  output logic [CUST_REGIF_ADDRW-1:0] cust_rg_addr_o,
  input  logic [MAX_DR_WIDTH-1:0]     cust_rg_dat_i,
  output logic [MAX_DR_WIDTH-1:0]     cust_rg_dat_o,
  output logic                        cust_rg_capture_o,
  output logic                        cust_rg_update_o
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [MAX_DR_WIDTH-1:0] DR_ONE = MAX_DR_WIDTH'(1);

  tap_state_e                  state;
  tap_state_e                  state_nxt;
  logic [IR_WIDTH-1:0]         ir;
  logic [IR_WIDTH-1:0]         shift_ir;
  logic [MAX_DR_WIDTH-1:0]     shift_dr;
  logic                        sel_idcode;
  logic                        sel_bypass;
  logic                        cust_hit;
  logic [CUST_REGIF_ADDRW-1:0] cust_idx;
  logic [31:0]                 cust_len;
  logic [31:0]                 dr_len;
  logic [MAX_DR_WIDTH-1:0]     dr_mask;
  logic [MAX_DR_WIDTH-1:0]     dr_capture;
  logic [MAX_DR_WIDTH-1:0]     dr_shift;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PAU_DR;
      PAU_DR:  n = tms ? EX2_DR : PAU_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PAU_IR;
      PAU_IR:  n = tms ? EX2_IR : PAU_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  assign state_nxt = tap_next(state, tms_i);

  // Lowest-index custom match wins; IDCODE and BYPASS shadow any custom entry.
  always_comb begin
    cust_hit = 1'b0;
    cust_idx = '0;
    cust_len = 32'd1;
    for (int i = 0; i < NUM_CUST_REGS; i++) begin
      if (!cust_hit && ir == CUST_REG_ADDRS[i*IR_WIDTH +: IR_WIDTH]) begin
        cust_hit = 1'b1;
        cust_idx = CUST_REGIF_ADDRW'(i);
        cust_len = 32'(CUST_REG_WIDTHS[i*8 +: 8]);
      end
    end
  end

  assign sel_idcode    = (ir == IR_IDCODE);
  assign sel_bypass    = (ir == IR_BYPASS);
  assign cust_rg_val_o = cust_hit && !sel_idcode && !sel_bypass;
  assign cust_rg_addr_o = cust_idx;

  assign dr_len = sel_idcode ? 32'd32 : (cust_rg_val_o ? cust_len : 32'd1);

  // A shift of DR_ONE by the full width yields 0, so a full-width register
  // still gets an all-ones mask.
  assign dr_mask = (DR_ONE << dr_len) - DR_ONE;

  assign dr_capture = sel_idcode    ? MAX_DR_WIDTH'(IDCODE | 32'h1) :
                      cust_rg_val_o ? (cust_rg_dat_i & dr_mask) : '0;

  // Bits at and above dr_len stay zero, so the masked right shift only needs
  // tdi_i inserted at bit dr_len-1.
  assign dr_shift = ((shift_dr >> 1) & dr_mask) |
                    (MAX_DR_WIDTH'(tdi_i) << (dr_len - 32'd1));

  assign cust_rg_capture_o = cust_rg_val_o && (state == CAP_DR);
  assign cust_rg_update_o  = cust_rg_val_o && (state == UPD_DR);
  assign tap_state_o       = state;
  assign ir_o              = ir;

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      state         <= TLR;
      ir            <= IR_IDCODE;
      shift_ir      <= '0;
      shift_dr      <= '0;
      cust_rg_dat_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        TLR:    ir <= IR_IDCODE;
        // SEL_IR is the only other way into TLR; the IR is already IDCODE on arrival.
        SEL_IR: if (tms_i) ir <= IR_IDCODE;
        CAP_IR: shift_ir <= IR_WIDTH'(2'b01);
        SH_IR:  shift_ir <= {tdi_i, shift_ir[IR_WIDTH-1:1]};
        UPD_IR: ir <= shift_ir;
        CAP_DR: shift_dr <= dr_capture;
        SH_DR:  shift_dr <= dr_shift;
        UPD_DR: if (cust_rg_val_o) cust_rg_dat_o <= shift_dr;
        default: ;
      endcase
    end
  end

  always_ff @(negedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      case (state)
        SH_IR: begin
          tdo_o    <= shift_ir[0];
          tdo_oe_o <= 1'b1;
        end
        SH_DR: begin
          tdo_o    <= shift_dr[0];
          tdo_oe_o <= 1'b1;
        end
        default: begin
          tdo_o    <= 1'b0;
          tdo_oe_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_mr.sv
// tb_jtag_tap_mr: directed bench for jtag_tap_mr (IDCODE overridden to 32'h1000_0A6E).
module tb_jtag_tap_mr;

  logic        tck_i = 1'b0;
  logic        trst_n_i = 1'b1;
  logic        tms_i = 1'b1;
  logic        tdi_i = 1'b0;
  logic        tdo_o;
  logic        tdo_oe_o;
  logic [3:0]  tap_state_o;
  logic [4:0]  ir_o;
  logic        cust_rg_val_o;
  logic [0:0]  cust_rg_addr_o;
  logic [63:0] cust_rg_dat_i = '0;
  logic [63:0] cust_rg_dat_o;
  logic        cust_rg_capture_o;
  logic        cust_rg_update_o;

  int total = 0;
  int bad = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;

  jtag_tap_mr #(.IDCODE(32'h1000_0A6E)) dut (
    .tck_i             (tck_i),
    .trst_n_i          (trst_n_i),
    .tms_i             (tms_i),
    .tdi_i             (tdi_i),
    .tdo_o             (tdo_o),
    .tdo_oe_o          (tdo_oe_o),
    .tap_state_o       (tap_state_o),
    .ir_o              (ir_o),
    .cust_rg_val_o     (cust_rg_val_o),
    .cust_rg_addr_o    (cust_rg_addr_o),
    .cust_rg_dat_i     (cust_rg_dat_i),
    .cust_rg_dat_o     (cust_rg_dat_o),
    .cust_rg_capture_o (cust_rg_capture_o),
    .cust_rg_update_o  (cust_rg_update_o)
  );

  always #5 tck_i = ~tck_i;

  // Strobes are stable between posedges, so each pulse is seen at exactly one negedge.
  always @(negedge tck_i) begin
    if (cust_rg_capture_o) cap_cnt++;
    if (cust_rg_update_o)  upd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    tms_i = tms;
    tdi_i = tdi;
    @(posedge tck_i);
    @(negedge tck_i);
    #1;
  endtask

  task automatic do_reset();
    tms_i = 1'b1;
    trst_n_i = 1'b0;
    #2;
    trst_n_i = 1'b1;
  endtask

  // From RTI back to RTI; cap holds the TDO bits seen while shifting, LSB first.
  task automatic ir_scan(input logic [4:0] val, output logic [4:0] cap);
    cap = '0;
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 5; i++) begin
      cap[i] = tdo_o;
      step(i == 4, val[i]);
    end
    step(1, 0);
    step(0, 0);
  endtask

  // From RTI back to RTI. After bits p1 and p2 the scan detours through
  // EX1_DR/PAU_DR (5 paused edges, tdi toggled high)/EX2_DR.
  task automatic dr_scan(input logic [63:0] din, input int len, input int p1, input int p2,
                         output logic [63:0] dout, output logic oe_in, output logic oe_out);
    dout = '0;
    oe_in = 1'b1;
    oe_out = 1'b0;
    step(1, 0); oe_out |= tdo_oe_o;
    step(0, 0); oe_out |= tdo_oe_o;
    step(0, 0);
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo_o;
      oe_in &= tdo_oe_o;
      if ((i == p1 || i == p2) && i < len - 1) begin
        step(1, din[i]); oe_out |= tdo_oe_o;
        step(0, 1);      oe_out |= tdo_oe_o;
        for (int k = 0; k < 4; k++) begin
          step(0, 1); oe_out |= tdo_oe_o;
        end
        step(1, 1); oe_out |= tdo_oe_o;
        step(0, 1);
      end else begin
        step(i == len - 1, din[i]);
      end
    end
    oe_out |= tdo_oe_o;
    step(1, 0); oe_out |= tdo_oe_o;
    step(0, 0); oe_out |= tdo_oe_o;
  endtask

  logic [7:0]  pth [16];
  int          plen [16];
  logic [4:0]  irout;
  logic [63:0] dout;
  logic        oe_in, oe_out;
  int          cap0, upd0;

  localparam logic [63:0] CUST_IN  = 64'hFFFF_FE12_3456_789A;
  localparam logic [63:0] CUST_CAP = 64'h0000_0012_3456_789A;
  localparam logic [63:0] CUST_DIN = 64'h0000_000A_AAA5_555A;

  initial begin
    // TMS paths from RTI to each state, applied LSB first.
    pth[0]  = 8'b111;    plen[0]  = 3;
    pth[1]  = 8'b0;      plen[1]  = 0;
    pth[2]  = 8'b1;      plen[2]  = 1;
    pth[3]  = 8'b01;     plen[3]  = 2;
    pth[4]  = 8'b001;    plen[4]  = 3;
    pth[5]  = 8'b101;    plen[5]  = 3;
    pth[6]  = 8'b0101;   plen[6]  = 4;
    pth[7]  = 8'b10101;  plen[7]  = 5;
    pth[8]  = 8'b1101;   plen[8]  = 4;
    pth[9]  = 8'b11;     plen[9]  = 2;
    pth[10] = 8'b011;    plen[10] = 3;
    pth[11] = 8'b0011;   plen[11] = 4;
    pth[12] = 8'b1011;   plen[12] = 4;
    pth[13] = 8'b01011;  plen[13] = 5;
    pth[14] = 8'b101011; plen[14] = 6;
    pth[15] = 8'b11011;  plen[15] = 5;

    #1 trst_n_i = 1'b0;
    #2;
    check("rst_state", 64'(tap_state_o), 64'd0);
    check("rst_ir", 64'(ir_o), 64'h01);
    check("rst_tdo", 64'(tdo_o), 64'd0);
    check("rst_oe", 64'(tdo_oe_o), 64'd0);
    check("rst_dat_o", cust_rg_dat_o, 64'd0);
    check("rst_strobes", {62'd0, cust_rg_capture_o, cust_rg_update_o}, 64'd0);
    @(negedge tck_i);
    #1 trst_n_i = 1'b1;

    for (int s = 0; s < 16; s++) begin
      step(0, 0);
      ir_scan(5'h10, irout);
      check("fsm_ir_pre", 64'(ir_o), 64'h10);
      for (int k = 0; k < plen[s]; k++) step(pth[s][k], 0);
      check($sformatf("fsm_reach_%0d", s), 64'(tap_state_o), 64'(s));
      for (int k = 0; k < 5; k++) step(1, 1);
      check($sformatf("fsm_tlr_%0d", s), 64'(tap_state_o), 64'd0);
      check($sformatf("fsm_ir_%0d", s), 64'(ir_o), 64'h01);
    end

    do_reset();
    step(0, 0);
    cap0 = cap_cnt; upd0 = upd_cnt;
    dr_scan(64'd0, 32, -1, -1, dout, oe_in, oe_out);
    check("idcode_tdo", dout, 64'h1000_0A6F);
    check("idcode_oe_shift", 64'(oe_in), 64'd1);
    check("idcode_oe_idle", 64'(oe_out), 64'd0);
    check("idcode_strobes", 64'((cap_cnt - cap0) + (upd_cnt - upd0)), 64'd0);

    ir_scan(5'h1F, irout);
    check("ir_capture", 64'(irout), 64'h01);
    check("ir_bypass", 64'(ir_o), 64'h1F);
    check("bypass_val", 64'(cust_rg_val_o), 64'd0);
    cap0 = cap_cnt; upd0 = upd_cnt;
    dr_scan(64'h01, 8, -1, -1, dout, oe_in, oe_out);
    check("bypass_tdo", dout, 64'h02);
    check("bypass_strobes", 64'((cap_cnt - cap0) + (upd_cnt - upd0)), 64'd0);

    ir_scan(5'h05, irout);
    check("unknown_val", 64'(cust_rg_val_o), 64'd0);
    dr_scan(64'h0D, 8, -1, -1, dout, oe_in, oe_out);
    check("unknown_tdo", dout, 64'h1A);

    ir_scan(5'h10, irout);
    check("cust0_sel", {62'd0, cust_rg_val_o, cust_rg_addr_o}, 64'h2);

    do_reset();
    step(0, 0);
    ir_scan(5'h11, irout);
    check("cust1_sel", {62'd0, cust_rg_val_o, cust_rg_addr_o}, 64'h3);
    cust_rg_dat_i = CUST_IN;
    cap0 = cap_cnt; upd0 = upd_cnt;
    dr_scan(CUST_DIN, 41, -1, -1, dout, oe_in, oe_out);
    check("cust_tdo", dout, CUST_CAP);
    check("cust_cap_cnt", 64'(cap_cnt - cap0), 64'd1);
    check("cust_upd_cnt", 64'(upd_cnt - upd0), 64'd1);
    check("cust_dat_o", cust_rg_dat_o, CUST_DIN);

    do_reset();
    check("rst2_dat_o", cust_rg_dat_o, 64'd0);
    step(0, 0);
    ir_scan(5'h11, irout);
    cap0 = cap_cnt; upd0 = upd_cnt;
    dr_scan(CUST_DIN, 41, 10, 25, dout, oe_in, oe_out);
    check("pause_tdo", dout, CUST_CAP);
    check("pause_oe_idle", 64'(oe_out), 64'd0);
    check("pause_cap_cnt", 64'(cap_cnt - cap0), 64'd1);
    check("pause_upd_cnt", 64'(upd_cnt - upd0), 64'd1);
    check("pause_dat_o", cust_rg_dat_o, CUST_DIN);

    upd0 = upd_cnt;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 10; i++) step(0, 1);
    check("midrst_pre_oe", 64'(tdo_oe_o), 64'd1);
    trst_n_i = 1'b0;
    #1;
    check("midrst_state", 64'(tap_state_o), 64'd0);
    check("midrst_oe", 64'(tdo_oe_o), 64'd0);
    check("midrst_dat_o", cust_rg_dat_o, 64'd0);
    check("midrst_ir", 64'(ir_o), 64'h01);
    #1 trst_n_i = 1'b1;
    for (int k = 0; k < 3; k++) step(1, 0);
    check("midrst_no_upd", 64'(upd_cnt - upd0), 64'd0);
    check("midrst_tlr", 64'(tap_state_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
